ppm_freq_tune_ctrl: RTL and testbench

//   Closed-loop controller for PPM preamble frequency recovery. Consumes interpulse-cycle

---
 rtl/ppm_freq_tune_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ppm_freq_tune_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppm_freq_tune_ctrl.sv
// ppm_freq_tune_ctrl
// Closed-loop oscillator tuning for PPM preamble frequency recovery.
// Averaged interpulse-cycle measurements drive the DAC code. Acquisition
// uses a successive-approximation search over the code bits, followed by
// one verify window. Once locked, the controller tracks the target with
// +/-1 code steps. freq_ok tells the recovery block to stop scanning.
module ppm_freq_tune_ctrl #(
    parameter int MEAS_BITS     = 17,
    parameter int DAC_BITS      = 6,
    parameter int AVG_LOG2      = 2,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 meas_valid,
    input  logic [MEAS_BITS-1:0] meas,
    input  logic [MEAS_BITS-1:0] target_cycles,
    input  logic [MEAS_BITS-1:0] tol,
    output logic [DAC_BITS-1:0]  dac_code,
    output logic                 freq_ok,
    output logic                 busy,
    output logic                 lock_fail,
    output logic [MEAS_BITS-1:0] avg_cycles,
    output logic [2:0]           state_SC
);

    localparam int ACC_W = MEAS_BITS + AVG_LOG2;
    localparam int CMP_W = MEAS_BITS + 1;
    localparam int IDX_W = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SMP_W = AVG_LOG2 + 1;

    localparam logic [DAC_BITS-1:0] DAC_MID  = {1'b1, {(DAC_BITS-1){1'b0}}};
    localparam logic [DAC_BITS-1:0] DAC_MAX  = {DAC_BITS{1'b1}};
    localparam logic [DAC_BITS-1:0] DAC_ZERO = {DAC_BITS{1'b0}};
    localparam logic [IDX_W-1:0]    IDX_MSB  = IDX_W'(DAC_BITS - 1);
    localparam logic [IDX_W-1:0]    IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SMP_W-1:0]    SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_SAR    = 2'd0,
        MODE_VERIFY = 2'd1,
        MODE_TRACK  = 2'd2
    } mode_e;

    state_e               state_q,      state_d;
    mode_e                mode_q,       mode_d;
    logic [DAC_BITS-1:0]  dac_code_q,   dac_code_d;
    logic [IDX_W-1:0]     bit_idx_q,    bit_idx_d;
    logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
    logic [SMP_W-1:0]     samp_cnt_q,   samp_cnt_d;
    logic [ACC_W-1:0]     acc_q,        acc_d;
    logic [MEAS_BITS-1:0] avg_cycles_q, avg_cycles_d;
    logic                 freq_ok_q,    freq_ok_d;
    logic                 busy_q,       busy_d;
    logic                 lock_fail_q,  lock_fail_d;

    logic [ACC_W-1:0]     sum_s;
    logic [MEAS_BITS-1:0] avg_s;
    logic                 hi_s;
    logic                 lo_s;
    logic                 in_band_s;
    logic                 step_ok_s;
    logic [DAC_BITS-1:0]  step_code_s;
    logic [DAC_BITS-1:0]  sar_code_s;

    // Window average and in-band test; one extra MSB keeps target+tol and avg+tol from wrapping
    always_comb begin
        if (state_q == ST_LOCKED) begin
            sum_s = acc_q + ACC_W'(meas);
        end else begin
            sum_s = acc_q;
        end
        avg_s     = MEAS_BITS'(sum_s >> AVG_LOG2);
        hi_s      = {1'b0, avg_s} > ({1'b0, target_cycles} + {1'b0, tol});
        lo_s      = ({1'b0, avg_s} + {1'b0, tol}) < CMP_W'({1'b0, target_cycles});
        in_band_s = !hi_s && !lo_s;
    end

    // Candidate codes: +/-1 tracking step and next SAR trial code
    always_comb begin
        step_ok_s = (hi_s && (dac_code_q != DAC_ZERO)) || (lo_s && (dac_code_q != DAC_MAX));
        if (hi_s) begin
            step_code_s = dac_code_q - {{(DAC_BITS-1){1'b0}}, 1'b1};
        end else begin
            step_code_s = dac_code_q + {{(DAC_BITS-1){1'b0}}, 1'b1};
        end
        sar_code_s = dac_code_q;
        if (hi_s) begin
            sar_code_s[bit_idx_q] = 1'b0;
        end else begin
            sar_code_s[bit_idx_q] = dac_code_q[bit_idx_q];
        end
        if (bit_idx_q != IDX_ZERO) begin
            sar_code_s[bit_idx_q - {{(IDX_W-1){1'b0}}, 1'b1}] = 1'b1;
        end else begin
            sar_code_s = sar_code_s;
        end
    end

    // Next-state and datapath update for the acquisition/tracking FSM
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        dac_code_d   = dac_code_q;
        bit_idx_d    = bit_idx_q;
        settle_cnt_d = settle_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        acc_d        = acc_q;
        avg_cycles_d = avg_cycles_q;

        if (!en) begin
            state_d      = ST_IDLE;
            acc_d        = {ACC_W{1'b0}};
            samp_cnt_d   = {SMP_W{1'b0}};
            settle_cnt_d = {SET_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_SETTLE;
                    dac_code_d   = DAC_MID;
                    bit_idx_d    = IDX_MSB;
                    mode_d       = MODE_SAR;
                    settle_cnt_d = {SET_W{1'b0}};
                    samp_cnt_d   = {SMP_W{1'b0}};
                    acc_d        = {ACC_W{1'b0}};
                end
                ST_SETTLE: begin
                    // samples arriving while the oscillator settles are dropped
                    if (settle_cnt_q == SET_LAST) begin
                        settle_cnt_d = {SET_W{1'b0}};
                        state_d      = ST_ACCUM;
                    end else begin
                        settle_cnt_d = settle_cnt_q + {{(SET_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_ACCUM: begin
                    if (meas_valid) begin
                        acc_d = acc_q + ACC_W'(meas);
                        if (samp_cnt_q == SMP_LAST) begin
                            samp_cnt_d = {SMP_W{1'b0}};
                            state_d    = ST_DECIDE;
                        end else begin
                            samp_cnt_d = samp_cnt_q + {{(SMP_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        acc_d = acc_q;
                    end
                end
                ST_DECIDE: begin
                    avg_cycles_d = avg_s;
                    acc_d        = {ACC_W{1'b0}};
                    samp_cnt_d   = {SMP_W{1'b0}};
                    case (mode_q)
                        MODE_SAR: begin
                            if (in_band_s) begin
                                state_d = ST_LOCKED;
                            end else begin
                                dac_code_d = sar_code_s;
                                state_d    = ST_SETTLE;
                                if (bit_idx_q != IDX_ZERO) begin
                                    bit_idx_d = bit_idx_q - {{(IDX_W-1){1'b0}}, 1'b1};
                                end else begin
                                    // last bit resolved: one more window on the final code
                                    mode_d = MODE_VERIFY;
                                end
                            end
                        end
                        MODE_VERIFY: begin
                            if (in_band_s) begin
                                state_d = ST_LOCKED;
                            end else begin
                                state_d = ST_FAIL;
                            end
                        end
                        default: begin
                            if (in_band_s) begin
                                state_d = ST_LOCKED;
                            end else if (step_ok_s) begin
                                dac_code_d = step_code_s;
                                state_d    = ST_SETTLE;
                            end else begin
                                state_d = ST_FAIL;
                            end
                        end
                    endcase
                end
                ST_LOCKED: begin
                    // continuous windows with no settle; window close evaluated inline
                    if (meas_valid) begin
                        if (samp_cnt_q == SMP_LAST) begin
                            avg_cycles_d = avg_s;
                            acc_d        = {ACC_W{1'b0}};
                            samp_cnt_d   = {SMP_W{1'b0}};
                            if (in_band_s) begin
                                state_d = ST_LOCKED;
                            end else if (step_ok_s) begin
                                mode_d     = MODE_TRACK;
                                dac_code_d = step_code_s;
                                state_d    = ST_SETTLE;
                            end else begin
                                mode_d  = MODE_TRACK;
                                state_d = ST_FAIL;
                            end
                        end else begin
                            acc_d      = acc_q + ACC_W'(meas);
                            samp_cnt_d = samp_cnt_q + {{(SMP_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        acc_d = acc_q;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        freq_ok_d   = (state_d == ST_LOCKED);
        lock_fail_d = (state_d == ST_FAIL);
        busy_d      = (state_d == ST_SETTLE) || (state_d == ST_ACCUM) || (state_d == ST_DECIDE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_SAR;
            dac_code_q   <= DAC_MID;
            bit_idx_q    <= IDX_MSB;
            settle_cnt_q <= {SET_W{1'b0}};
            samp_cnt_q   <= {SMP_W{1'b0}};
            acc_q        <= {ACC_W{1'b0}};
            avg_cycles_q <= {MEAS_BITS{1'b0}};
            freq_ok_q    <= 1'b0;
            busy_q       <= 1'b0;
            lock_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            dac_code_q   <= dac_code_d;
            bit_idx_q    <= bit_idx_d;
            settle_cnt_q <= settle_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            acc_q        <= acc_d;
            avg_cycles_q <= avg_cycles_d;
            freq_ok_q    <= freq_ok_d;
            busy_q       <= busy_d;
            lock_fail_q  <= lock_fail_d;
        end
    end

    assign dac_code   = dac_code_q;
    assign freq_ok    = freq_ok_q;
    assign busy       = busy_q;
    assign lock_fail  = lock_fail_q;
    assign avg_cycles = avg_cycles_q;
    assign state_SC   = state_q;

endmodule

// File: tb/tb_ppm_freq_tune_ctrl.sv
// Directed testbench for ppm_freq_tune_ctrl with a simple oscillator model:
// meas = 900 + 16*dac_code + shift, one strobe every 8 clk.
module tb_ppm_freq_tune_ctrl;

    localparam int MB = 17;
    localparam int DB = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_ACCUM  = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    logic          clk;
    logic          resetn;
    logic          en;
    logic          meas_valid;
    logic [MB-1:0] meas;
    logic [MB-1:0] target_cycles;
    logic [MB-1:0] tol;
    logic [DB-1:0] dac_code;
    logic          freq_ok;
    logic          busy;
    logic          lock_fail;
    logic [MB-1:0] avg_cycles;
    logic [2:0]    state_SC;

    logic          osc_valid;
    logic [MB-1:0] osc_meas;
    logic          inj_on;
    logic [MB-1:0] inj_meas;
    int            shift;

    int            tests;
    int            fails;
    logic [DB-1:0] seq [0:7];
    int            seq_n;
    logic [DB-1:0] dac_prev;
    int            dec_n;
    logic          prev_mv;
    logic [MB-1:0] avg_before;

    assign meas_valid = inj_on ? 1'b1 : osc_valid;
    assign meas       = inj_on ? inj_meas : osc_meas;

    ppm_freq_tune_ctrl #(
        .MEAS_BITS(MB), .DAC_BITS(DB), .AVG_LOG2(1), .SETTLE_CYCLES(4)
    ) dut (
        .clk(clk), .resetn(resetn), .en(en), .meas_valid(meas_valid), .meas(meas),
        .target_cycles(target_cycles), .tol(tol), .dac_code(dac_code), .freq_ok(freq_ok),
        .busy(busy), .lock_fail(lock_fail), .avg_cycles(avg_cycles), .state_SC(state_SC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // oscillator model: strobe raised 2 time units after a posedge, one clk wide
    initial begin
        osc_valid = 1'b0;
        osc_meas  = '0;
        forever begin
            repeat (7) @(posedge clk);
            #2;
            osc_meas  = MB'(900 + 16 * int'(dac_code) + shift);
            osc_valid = 1'b1;
            @(posedge clk);
            #2;
            osc_valid = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic track_reset();
        seq_n    = 0;
        dec_n    = 0;
        dac_prev = dac_code;
    endtask

    // advance on negedges until state_SC==st or budget expires; logs code changes and decisions
    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (state_SC !== st && n < budget) begin
            @(negedge clk);
            n++;
            if (dac_code !== dac_prev) begin
                if (seq_n < 8) seq[seq_n] = dac_code;
                seq_n++;
                dac_prev = dac_code;
            end
            if (state_SC === S_DECIDE) dec_n++;
        end
        check(tag, 32'(state_SC), 32'(st));
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        shift         = 0;
        inj_on        = 1'b0;
        inj_meas      = '0;
        resetn        = 1'b0;
        en            = 1'b0;
        target_cycles = 17'd1000;
        tol           = 17'd8;
        seq_n         = 0;
        dec_n         = 0;
        dac_prev      = '0;
        prev_mv       = 1'b0;
        avg_before    = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_SC), 32'(S_IDLE));
        check("rst_dac", 32'(dac_code), 32'd8);
        check("rst_avg", 32'(avg_cycles), 32'd0);
        check("rst_flags", {29'd0, freq_ok, busy, lock_fail}, 32'd0);
        resetn = 1'b1;

        // 1: SAR acquisition target 1000 tol 8
        @(negedge clk);
        track_reset();
        en = 1'b1;
        wait_state("t1_locked", S_LOCKED, 2000);
        check("t1_freq_ok", 32'(freq_ok), 32'd1);
        check("t1_dac", 32'(dac_code), 32'd6);
        check("t1_avg", 32'(avg_cycles), 32'd996);
        check("t1_decisions", 32'(dec_n), 32'd3);
        check("t1_nchanges", 32'(seq_n), 32'd2);
        check("t1_code0", 32'(seq[0]), 32'd4);
        check("t1_code1", 32'(seq[1]), 32'd6);
        check("t1_busy", 32'(busy), 32'd0);

        // 3: model shifts +20 while locked
        shift = 20;
        begin
            int n;
            n = 0;
            while (freq_ok === 1'b1 && n < 400) begin
                prev_mv = meas_valid;
                @(negedge clk);
                n++;
            end
        end
        check("t3_drop", 32'(freq_ok), 32'd0);
        check("t3_drop_timing", 32'(prev_mv), 32'd1);
        check("t3_dac_step", 32'(dac_code), 32'd5);
        check("t3_avg_hi", 32'(avg_cycles), 32'd1016);
        check("t3_state", 32'(state_SC), 32'(S_SETTLE));
        wait_state("t3_relock", S_LOCKED, 2000);
        check("t3_freq_ok", 32'(freq_ok), 32'd1);
        check("t3_avg", 32'(avg_cycles), 32'd1000);
        check("t3_dac", 32'(dac_code), 32'd5);

        // 2: target 1000 tol 0 -> VERIFY fails
        en    = 1'b0;
        shift = 0;
        @(negedge clk);
        check("t2_idle", 32'(state_SC), 32'(S_IDLE));
        tol = 17'd0;
        track_reset();
        en = 1'b1;
        wait_state("t2_fail", S_FAIL, 3000);
        check("t2_lock_fail", 32'(lock_fail), 32'd1);
        check("t2_freq_ok", 32'(freq_ok), 32'd0);
        check("t2_dac", 32'(dac_code), 32'd6);
        check("t2_avg", 32'(avg_cycles), 32'd996);
        check("t2_decisions", 32'(dec_n), 32'd5);
        check("t2_nchanges", 32'(seq_n), 32'd5);
        check("t2_code0", 32'(seq[0]), 32'd8);
        check("t2_code1", 32'(seq[1]), 32'd4);
        check("t2_code2", 32'(seq[2]), 32'd6);
        check("t2_code3", 32'(seq[3]), 32'd7);
        check("t2_code4", 32'(seq[4]), 32'd6);

        // 4: spurious sample with meas=0 during SETTLE is ignored
        en = 1'b0;
        @(negedge clk);
        tol = 17'd8;
        track_reset();
        en = 1'b1;
        wait_state("t4_settle", S_SETTLE, 20);
        avg_before = avg_cycles;
        inj_meas   = '0;
        inj_on     = 1'b1;
        @(negedge clk);
        inj_on = 1'b0;
        check("t4_avg_hold", 32'(avg_cycles), 32'd996);
        check("t4_busy", 32'(busy), 32'd1);
        wait_state("t4_decide", S_DECIDE, 200);
        @(negedge clk);
        check("t4_first_avg", 32'(avg_cycles), 32'd1028);
        wait_state("t4_locked", S_LOCKED, 2000);
        check("t4_dac", 32'(dac_code), 32'd6);

        // 5: unreachable target, then en=0
        en = 1'b0;
        @(negedge clk);
        target_cycles = 17'd5000;
        track_reset();
        en = 1'b1;
        wait_state("t5_fail", S_FAIL, 3000);
        check("t5_lock_fail", 32'(lock_fail), 32'd1);
        check("t5_dac", 32'(dac_code), 32'd15);
        check("t5_avg", 32'(avg_cycles), 32'd1140);
        check("t5_freq_ok", 32'(freq_ok), 32'd0);
        repeat (5) @(negedge clk);
        check("t5_fail_held", 32'(lock_fail), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("t5_idle", 32'(state_SC), 32'(S_IDLE));
        check("t5_lock_fail_clr", 32'(lock_fail), 32'd0);
        check("t5_dac_hold", 32'(dac_code), 32'd15);

        // 6: reset mid-ACCUM, then reacquire
        target_cycles = 17'd1000;
        en = 1'b1;
        wait_state("t6_accum", S_ACCUM, 50);
        resetn = 1'b0;
        en     = 1'b0;
        @(negedge clk);
        check("t6_state", 32'(state_SC), 32'(S_IDLE));
        check("t6_dac", 32'(dac_code), 32'd8);
        check("t6_avg", 32'(avg_cycles), 32'd0);
        check("t6_flags", {29'd0, freq_ok, busy, lock_fail}, 32'd0);
        resetn = 1'b1;
        track_reset();
        en = 1'b1;
        wait_state("t6_locked", S_LOCKED, 2000);
        check("t6_dac_lock", 32'(dac_code), 32'd6);
        check("t6_avg_lock", 32'(avg_cycles), 32'd996);
        check("t6_decisions", 32'(dec_n), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
